// File: rtl/hsv_adjust_if.sv
// Pixel stream bundle: syncs, data enable and one HSV triple.
// The DUT receives on the slave modport and produces on the master modport.
interface hsv_adjust_if;
  logic       vs;
  logic       hs;
  logic       de;
  logic [8:0] h;
  logic [8:0] s;
  logic [7:0] v;

  modport master (output vs, hs, de, h, s, v);
  modport slave  (input  vs, hs, de, h, s, v);
endinterface

// File: rtl/hsv_adjust.sv
// Three-stage hue rotate / saturation and value gain stage with frame-aligned,
// double-buffered configuration and matched sync delays.
module hsv_adjust #(
  parameter int GAIN_FRAC = 7,
  parameter int HUE_MAX   = 360
) (
  input  logic          clk,
  input  logic          reset,
  hsv_adjust_if.slave   px_in,
  hsv_adjust_if.master  px_out,
  input  logic [8:0]    cfg_hue_offset,
  input  logic [7:0]    cfg_sat_gain,
  input  logic [7:0]    cfg_val_gain,
  input  logic          cfg_bypass,
  input  logic          cfg_update,
  output logic          cfg_pending
);

  localparam logic [7:0]  GAIN_ONE = 8'(1 << GAIN_FRAC);
  localparam logic [16:0] ROUND_HALF = 17'(1 << (GAIN_FRAC - 1));

  function automatic logic [7:0] scale_round(input logic [15:0] p);
    logic [16:0] r;
    r = ({1'b0, p} + ROUND_HALF) >> GAIN_FRAC;
    return (r > 17'd255) ? 8'hFF : r[7:0];
  endfunction

  // Configuration: staged on host strobe, promoted to active on vs rising edge
  logic       vs_prev_reg;
  logic       frame_start;
  logic [8:0] cfg_off_clean;
  logic [8:0] staged_off_reg, act_off_reg;
  logic [7:0] staged_sat_reg, act_sat_reg;
  logic [7:0] staged_val_reg, act_val_reg;
  logic       staged_byp_reg, act_byp_reg;

  assign frame_start   = px_in.vs & ~vs_prev_reg;
  assign cfg_off_clean = (cfg_hue_offset >= 9'(HUE_MAX)) ? 9'd0 : cfg_hue_offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_reg    <= 1'b0;
      cfg_pending    <= 1'b0;
      staged_off_reg <= '0;
      staged_sat_reg <= '0;
      staged_val_reg <= '0;
      staged_byp_reg <= 1'b0;
      act_off_reg    <= '0;
      act_sat_reg    <= GAIN_ONE;
      act_val_reg    <= GAIN_ONE;
      act_byp_reg    <= 1'b0;
    end else begin
      vs_prev_reg <= px_in.vs;
      if (frame_start) begin
        cfg_pending <= 1'b0;
        if (cfg_update) begin
          act_off_reg <= cfg_off_clean;
          act_sat_reg <= cfg_sat_gain;
          act_val_reg <= cfg_val_gain;
          act_byp_reg <= cfg_bypass;
        end else if (cfg_pending) begin
          act_off_reg <= staged_off_reg;
          act_sat_reg <= staged_sat_reg;
          act_val_reg <= staged_val_reg;
          act_byp_reg <= staged_byp_reg;
        end
      end else if (cfg_update) begin
        staged_off_reg <= cfg_off_clean;
        staged_sat_reg <= cfg_sat_gain;
        staged_val_reg <= cfg_val_gain;
        staged_byp_reg <= cfg_bypass;
        cfg_pending    <= 1'b1;
      end
    end
  end

  // Datapath; bypass travels with each pixel so a config swap never splits one
  logic [8:0]  h_clean;
  logic        unused_s8;
  logic [9:0]  s1_hsum_reg;
  logic [15:0] s1_sp_reg, s1_vp_reg;
  logic        s1_byp_reg, s2_byp_reg;
  logic [8:0]  s1_raw_h_reg, s2_raw_h_reg;
  logic [7:0]  s1_raw_s_reg, s2_raw_s_reg;
  logic [7:0]  s1_raw_v_reg, s2_raw_v_reg;
  logic [8:0]  s2_h_reg;
  logic [7:0]  s2_s_reg, s2_v_reg;
  logic [2:0]  vs_d_reg, hs_d_reg, de_d_reg;

  assign h_clean   = (px_in.h >= 9'(HUE_MAX)) ? 9'd0 : px_in.h;
  assign unused_s8 = px_in.s[8];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hsum_reg  <= '0;
      s1_sp_reg    <= '0;
      s1_vp_reg    <= '0;
      s1_byp_reg   <= 1'b0;
      s1_raw_h_reg <= '0;
      s1_raw_s_reg <= '0;
      s1_raw_v_reg <= '0;
      s2_h_reg     <= '0;
      s2_s_reg     <= '0;
      s2_v_reg     <= '0;
      s2_byp_reg   <= 1'b0;
      s2_raw_h_reg <= '0;
      s2_raw_s_reg <= '0;
      s2_raw_v_reg <= '0;
      px_out.h     <= '0;
      px_out.s     <= '0;
      px_out.v     <= '0;
      vs_d_reg     <= '0;
      hs_d_reg     <= '0;
      de_d_reg     <= '0;
    end else begin
      s1_hsum_reg  <= {1'b0, h_clean} + {1'b0, act_off_reg};
      s1_sp_reg    <= 16'(px_in.s[7:0]) * 16'(act_sat_reg);
      s1_vp_reg    <= 16'(px_in.v) * 16'(act_val_reg);
      s1_byp_reg   <= act_byp_reg;
      s1_raw_h_reg <= h_clean;
      s1_raw_s_reg <= px_in.s[7:0];
      s1_raw_v_reg <= px_in.v;

      s2_h_reg     <= (s1_hsum_reg >= 10'(HUE_MAX)) ? 9'(s1_hsum_reg - 10'(HUE_MAX))
                                                    : s1_hsum_reg[8:0];
      s2_s_reg     <= scale_round(s1_sp_reg);
      s2_v_reg     <= scale_round(s1_vp_reg);
      s2_byp_reg   <= s1_byp_reg;
      s2_raw_h_reg <= s1_raw_h_reg;
      s2_raw_s_reg <= s1_raw_s_reg;
      s2_raw_v_reg <= s1_raw_v_reg;

      px_out.h     <= s2_byp_reg ? s2_raw_h_reg : s2_h_reg;
      px_out.s     <= {1'b0, (s2_byp_reg ? s2_raw_s_reg : s2_s_reg)};
      px_out.v     <= s2_byp_reg ? s2_raw_v_reg : s2_v_reg;

      vs_d_reg     <= {vs_d_reg[1:0], px_in.vs};
      hs_d_reg     <= {hs_d_reg[1:0], px_in.hs};
      de_d_reg     <= {de_d_reg[1:0], px_in.de};
    end
  end

  assign px_out.vs = vs_d_reg[2];
  assign px_out.hs = hs_d_reg[2];
  assign px_out.de = de_d_reg[2];

endmodule

// File: tb/tb_hsv_adjust.sv
// Directed-vector bench for hsv_adjust: driver queues hand-computed results,
// a negedge monitor pops and compares them when hsv_de is seen.
module tb_hsv_adjust;
  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] cfg_hue_offset;
  logic [7:0] cfg_sat_gain;
  logic [7:0] cfg_val_gain;
  logic       cfg_bypass;
  logic       cfg_update;
  logic       cfg_pending;

  hsv_adjust_if in_if ();
  hsv_adjust_if out_if ();

  hsv_adjust dut (
    .clk(clk), .reset(reset),
    .px_in(in_if), .px_out(out_if),
    .cfg_hue_offset(cfg_hue_offset), .cfg_sat_gain(cfg_sat_gain),
    .cfg_val_gain(cfg_val_gain), .cfg_bypass(cfg_bypass),
    .cfg_update(cfg_update), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       vs;
    logic       hs;
    logic [8:0] h;
    logic [8:0] s;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_if.de === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_de", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", cyc, e.cyc);
          check("h", int'(out_if.h), int'(e.h));
          check("s", int'(out_if.s), int'(e.s));
          check("v", int'(out_if.v), int'(e.v));
          check("vs", int'(out_if.vs), int'(e.vs));
          check("hs", int'(out_if.hs), int'(e.hs));
          $display("pixel @%0d: out h=%0d s=%0d v=%0d vs=%0b hs=%0b", cyc,
                   out_if.h, out_if.s, out_if.v, out_if.vs, out_if.hs);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check("missing_de", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of input; pixel values are sampled at the next rising edge
  task automatic drive(input logic vs_i, input logic hs_i, input logic de_i,
                       input logic [8:0] h, input logic [8:0] s, input logic [7:0] v,
                       input logic [8:0] eh, input logic [8:0] es, input logic [7:0] ev);
    exp_t e;
    @(posedge clk); #1;
    cfg_update = 1'b0;
    in_if.vs = vs_i; in_if.hs = hs_i; in_if.de = de_i;
    in_if.h = h; in_if.s = s; in_if.v = v;
    if (de_i) begin
      e.cyc = cyc + 3; e.vs = vs_i; e.hs = hs_i;
      e.h = eh; e.s = es; e.v = ev;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input logic vs_i);
    drive(vs_i, 1'b0, 1'b0, 9'd0, 9'd0, 8'd0, 9'd0, 9'd0, 8'd0);
  endtask

  task automatic px(input logic [8:0] h, input logic [8:0] s, input logic [7:0] v,
                    input logic [8:0] eh, input logic [8:0] es, input logic [7:0] ev);
    drive(1'b0, 1'b0, 1'b1, h, s, v, eh, es, ev);
  endtask

  // Stage a config, then open a frame so it becomes active
  task automatic apply_cfg(input logic [8:0] off, input logic [7:0] sg,
                           input logic [7:0] vg, input logic byp);
    idle(1'b0);
    cfg_hue_offset = off; cfg_sat_gain = sg; cfg_val_gain = vg; cfg_bypass = byp;
    cfg_update = 1'b1;
    idle(1'b0);
    check("pending_after_stage", int'(cfg_pending), 1);
    idle(1'b1);
    idle(1'b0);
    check("pending_after_frame", int'(cfg_pending), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_h"}, int'(out_if.h), 0);
    check({tag, "_s"}, int'(out_if.s), 0);
    check({tag, "_v"}, int'(out_if.v), 0);
    check({tag, "_syncs"}, int'({out_if.vs, out_if.hs, out_if.de}), 0);
    check({tag, "_pending"}, int'(cfg_pending), 0);
  endtask

  initial begin
    reset = 1'b1; cfg_update = 1'b0; cfg_bypass = 1'b0;
    cfg_hue_offset = 9'd0; cfg_sat_gain = 8'd128; cfg_val_gain = 8'd128;
    in_if.vs = 1'b0; in_if.hs = 1'b0; in_if.de = 1'b0;
    in_if.h = '0; in_if.s = '0; in_if.v = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;

    // Identity after reset
    px(9'd120, 9'd200, 8'd90, 9'd120, 9'd200, 8'd90);
    drive(1'b0, 1'b1, 1'b1, 9'd0, 9'd255, 8'd255, 9'd0, 9'd255, 8'd255);

    // Hue wrap with offset 20
    apply_cfg(9'd20, 8'd128, 8'd128, 1'b0);
    px(9'd350, 9'd100, 8'd50, 9'd10, 9'd100, 8'd50);
    px(9'd339, 9'd100, 8'd50, 9'd359, 9'd100, 8'd50);
    px(9'd400, 9'd100, 8'd50, 9'd20, 9'd100, 8'd50);

    // Saturation clamp and rounding
    apply_cfg(9'd0, 8'd255, 8'd128, 1'b0);
    px(9'd10, 9'd200, 8'd60, 9'd10, 9'd255, 8'd60);
    px(9'd10, 9'd0, 8'd60, 9'd10, 9'd0, 8'd60);
    apply_cfg(9'd0, 8'd64, 8'd128, 1'b0);
    px(9'd10, 9'd3, 8'd60, 9'd10, 9'd2, 8'd60);
    px(9'd10, 9'd0, 8'd60, 9'd10, 9'd0, 8'd60);

    // Value scaling, and s bit 8 ignored
    apply_cfg(9'd400, 8'd128, 8'd64, 1'b0);
    px(9'd30, 9'h1C8, 8'd201, 9'd30, 9'd200, 8'd101);
    apply_cfg(9'd0, 8'd128, 8'd128, 1'b0);
    px(9'd30, 9'd10, 8'd255, 9'd30, 9'd10, 8'd255);
    apply_cfg(9'd0, 8'd128, 8'd0, 1'b0);
    px(9'd30, 9'd10, 8'd200, 9'd30, 9'd10, 8'd0);

    // Bypass: raw values with h sanitised and s[8] dropped
    apply_cfg(9'd20, 8'd64, 8'd64, 1'b1);
    px(9'd400, 9'h1FF, 8'd77, 9'd0, 9'd255, 8'd77);
    px(9'd350, 9'd3, 8'd201, 9'd350, 9'd3, 8'd201);

    // Double buffering: staged mid-frame, active from pixel after vs rise
    apply_cfg(9'd0, 8'd128, 8'd128, 1'b0);
    idle(1'b0);
    cfg_hue_offset = 9'd90; cfg_update = 1'b1;
    px(9'd100, 9'd50, 8'd50, 9'd100, 9'd50, 8'd50);
    check("pending_midframe", int'(cfg_pending), 1);
    px(9'd100, 9'd50, 8'd50, 9'd100, 9'd50, 8'd50);
    drive(1'b1, 1'b0, 1'b1, 9'd100, 9'd50, 8'd50, 9'd100, 9'd50, 8'd50);
    px(9'd100, 9'd50, 8'd50, 9'd190, 9'd50, 8'd50);
    check("pending_cleared", int'(cfg_pending), 0);
    idle(1'b0);
    // Update coinciding with the vs rise goes straight to active
    drive(1'b1, 1'b0, 1'b1, 9'd100, 9'd50, 8'd50, 9'd190, 9'd50, 8'd50);
    cfg_hue_offset = 9'd10; cfg_update = 1'b1;
    px(9'd100, 9'd50, 8'd50, 9'd110, 9'd50, 8'd50);
    check("pending_on_rise", int'(cfg_pending), 0);
    px(9'd100, 9'd50, 8'd50, 9'd110, 9'd50, 8'd50);

    // Reset with pipeline full and a pending config
    cfg_hue_offset = 9'd90; cfg_sat_gain = 8'd0; cfg_update = 1'b1;
    px(9'd5, 9'd5, 8'd5, 9'd15, 9'd5, 8'd5);
    check("pending_before_reset", int'(cfg_pending), 1);
    px(9'd6, 9'd6, 8'd6, 9'd16, 9'd6, 8'd6);
    px(9'd7, 9'd7, 8'd7, 9'd17, 9'd7, 8'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check_outputs_zero("midreset");
    reset = 1'b0;
    in_if.de = 1'b0;
    idle(1'b1);
    idle(1'b0);
    px(9'd120, 9'd200, 8'd90, 9'd120, 9'd200, 8'd90);

    repeat (6) idle(1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
